// File: rtl/sine_ctrl_pkg.sv
// Shared definitions for the sine burst sequencer.
//   - Sizing constants: LUT_DEPTH, DATA_W, IDX_W, CNT_W
//   - state_e: sequencer FSM states
//   - SINE_LUT: one full period of the signed sine table
//   - clamp_step(): restricts the phase step to 1 .. LUT_DEPTH-1
package sine_ctrl_pkg;

    localparam int unsigned LUT_DEPTH = 30;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPresent,
        StDone
    } state_e;

    // The second half is the two's-complement negation of the first half.
    localparam logic [DATA_W-1:0] SINE_LUT [LUT_DEPTH] = '{
        8'h00, 8'h10, 8'h1F, 8'h2D, 8'h3A, 8'h43, 8'h4A, 8'h4D,
        8'h4D, 8'h4A, 8'h43, 8'h3A, 8'h2D, 8'h1F, 8'h10,
        8'h00, 8'hF0, 8'hE1, 8'hD3, 8'hC6, 8'hBD, 8'hB6, 8'hB3,
        8'hB3, 8'hB6, 8'hBD, 8'hC6, 8'hD3, 8'hE1, 8'hF0
    };

    // A zero step would never advance; a step of LUT_DEPTH or more would break
    // the single-subtract modulo wrap.
    function automatic logic [IDX_W-1:0] clamp_step(input logic [IDX_W-1:0] step);
        if (step == '0) begin
            return IDX_W'(1);
        end else if (step >= IDX_W'(LUT_DEPTH)) begin
            return IDX_W'(LUT_DEPTH - 1);
        end else begin
            return step;
        end
    endfunction

endpackage

// File: rtl/sine_burst_ctrl_if.sv
// Control and sample-stream bundle for sine_burst_ctrl.
// Signal names are from the sequencer's point of view.
//   start_i, stop_i, step_i, burst_len_i : burst configuration and control
//   sample_o, sample_valid_o, sample_ready_i : sample stream handshake
//   busy_o, done_o : status
//   amp_shift_i : amplitude shift, present only when SINE_BURST_AMP_EN is defined
// Modports: slave = sequencer, master = config logic and sample consumer.
interface sine_burst_ctrl_if;
    import sine_ctrl_pkg::*;

    logic              start_i;
    logic              stop_i;
    logic [IDX_W-1:0]  step_i;
    logic [CNT_W-1:0]  burst_len_i;
    logic [DATA_W-1:0] sample_o;
    logic              sample_valid_o;
    logic              sample_ready_i;
    logic              busy_o;
    logic              done_o;
`ifdef SINE_BURST_AMP_EN
    logic [2:0]        amp_shift_i;

    modport slave (
        input  start_i, stop_i, step_i, burst_len_i, sample_ready_i, amp_shift_i,
        output sample_o, sample_valid_o, busy_o, done_o
    );
    modport master (
        output start_i, stop_i, step_i, burst_len_i, sample_ready_i, amp_shift_i,
        input  sample_o, sample_valid_o, busy_o, done_o
    );
`else
    modport slave (
        input  start_i, stop_i, step_i, burst_len_i, sample_ready_i,
        output sample_o, sample_valid_o, busy_o, done_o
    );
    modport master (
        output start_i, stop_i, step_i, burst_len_i, sample_ready_i,
        input  sample_o, sample_valid_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/sine_lut_rom.sv
// Sine table ROM with a registered read port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rd_en_i       : capture SINE_LUT[addr_i] on the next rising edge
//   addr_i        : table index
//   data_o        : registered table value, held while rd_en_i is low
module sine_lut_rom
    import sine_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  addr_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (rd_en_i) begin
            data_d = (addr_i < IDX_W'(LUT_DEPTH)) ? SINE_LUT[addr_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sine_burst_ctrl.sv
// Sine burst sequencer: latches a phase step and burst length on start, walks
// the sine LUT modulo its depth and offers one sample per valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (assert async, release synchronised)
//   bus   : sine_burst_ctrl_if.slave (control, sample stream, status)
// Build option SINE_BURST_AMP_EN: adds amp_shift_i; the output sample is the
// table value arithmetically shifted right by the amount latched at start.
module sine_burst_ctrl
    import sine_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sine_burst_ctrl_if.slave  bus
);

    localparam logic [IDX_W:0] DepthExt = (IDX_W + 1)'(LUT_DEPTH);

    // Reset release synchroniser; assertion stays asynchronous.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    state_e           state_d, state_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [IDX_W-1:0] step_d, step_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] len_d, len_q;
    logic             valid_d, valid_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
`ifdef SINE_BURST_AMP_EN
    logic [2:0]       amp_d, amp_q;
`endif

    logic [IDX_W:0]    idx_sum;
    logic [IDX_W-1:0]  idx_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_sample;
    logic [DATA_W-1:0] rom_data;

    // step_q < LUT_DEPTH, so one conditional subtract keeps the index in range.
    assign idx_sum  = {1'b0, idx_q} + {1'b0, step_q};
    assign idx_next = (idx_sum >= DepthExt) ? IDX_W'(idx_sum - DepthExt) : idx_sum[IDX_W-1:0];

    // Saturating so continuous mode can run indefinitely.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign last_sample = (len_q != '0) && (cnt_q + CNT_W'(1) == len_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef SINE_BURST_AMP_EN
        amp_d   = amp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.stop_i) begin
                    step_d  = clamp_step(bus.step_i);
                    len_d   = bus.burst_len_i;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef SINE_BURST_AMP_EN
                    amp_d   = bus.amp_shift_i;
`endif
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = bus.stop_i ? StIdle : StPresent;
            end
            StPresent: begin
                if (bus.sample_ready_i) begin
                    // A handshake coinciding with stop is still accepted.
                    idx_d = idx_next;
                    cnt_d = cnt_inc;
                    if (bus.stop_i) begin
                        state_d = StIdle;
                    end else if (last_sample) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (bus.stop_i) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        valid_d = (state_d == StPresent);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            step_q  <= IDX_W'(1);
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SINE_BURST_AMP_EN
            amp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SINE_BURST_AMP_EN
            amp_q   <= amp_d;
`endif
        end
    end

    // Read issued during FETCH lands in the ROM register as PRESENT begins.
    sine_lut_rom u_rom (
        .clk_i   (clk),
        .rst_ni  (rst_sync_n),
        .rd_en_i (state_q == StFetch),
        .addr_i  (idx_q),
        .data_o  (rom_data)
    );

`ifdef SINE_BURST_AMP_EN
    assign bus.sample_o = DATA_W'($signed(rom_data) >>> amp_q);
`else
    assign bus.sample_o = rom_data;
`endif
    assign bus.sample_valid_o = valid_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;

endmodule
